// File: rtl/tdm_demux_1x8_if.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x8_if
// Bundles the serial stream input, the frame output handshake and the status
// flags of tdm_demux_1x8.
//   slave  : demux side (consumes the stream, drives frame and status)
//   master : environment side (drives the stream and out_ready)
// Signals:
//   in, in_valid, frame_sync : serial beat, qualifier, slot-0 marker
//   out[7:0], out_valid      : completed frame and its valid flag
//   out_ready                : consumer accept
//   slot[2:0]                : slot index expected on the next beat
//   locked, sync_err, overrun: lock status and one-cycle event pulses
// ---------------------------------------------------------------------------
interface tdm_demux_1x8_if;
    logic       in;
    logic       in_valid;
    logic       frame_sync;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] slot;
    logic       locked;
    logic       sync_err;
    logic       overrun;

    modport slave (
        input  in, in_valid, frame_sync, out_ready,
        output out, out_valid, slot, locked, sync_err, overrun
    );

    modport master (
        output in, in_valid, frame_sync, out_ready,
        input  out, out_valid, slot, locked, sync_err, overrun
    );
endinterface

// File: rtl/tdm_demux_1x8.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x8
// Rebuilds 8-bit words from a 1-bit time-division stream. Each valid beat is
// written into its slot position of a shadow register; the slot-7 beat
// completes the frame, which is presented through a valid/ready output
// register. frame_sync marks slot 0 and is used to acquire and check lock.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demux_1x8_if.slave (stream in, frame out, status)
// Parameter:
//   SYNC_EVERY_FRAME : 1 = frame_sync required on every slot-0 beat while
//                      locked; 0 = frame_sync only needed to acquire lock
// ---------------------------------------------------------------------------
// state  | meaning
// HUNT   | waiting for a beat carrying frame_sync; other beats discarded
// LOCKED | aligned to the frame; each beat fills the expected slot
// ---------------------------------------------------------------------------
module tdm_demux_1x8 #(
    parameter bit SYNC_EVERY_FRAME = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    tdm_demux_1x8_if.slave  bus
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state_q, state_nxt;
    logic [2:0] slot_q, slot_nxt;
    logic [7:0] shadow_q, shadow_nxt;
    logic [7:0] out_q, out_nxt;
    logic       out_valid_q, out_valid_nxt;
    logic       sync_err_q, sync_err_nxt;
    logic       overrun_q, overrun_nxt;
    logic       complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= 3'd0;
            shadow_q    <= 8'd0;
            out_q       <= 8'd0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            slot_q      <= slot_nxt;
            shadow_q    <= shadow_nxt;
            out_q       <= out_nxt;
            out_valid_q <= out_valid_nxt;
            sync_err_q  <= sync_err_nxt;
            overrun_q   <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        slot_nxt      = slot_q;
        shadow_nxt    = shadow_q;
        out_nxt       = out_q;
        out_valid_nxt = out_valid_q;
        sync_err_nxt  = 1'b0;
        overrun_nxt   = 1'b0;
        complete      = 1'b0;

        if (bus.in_valid) begin
            if (state_q == HUNT) begin
                if (bus.frame_sync) begin
                    shadow_nxt[0] = bus.in;
                    slot_nxt      = 3'd1;
                    state_nxt     = LOCKED;
                end
            end else begin
                if (bus.frame_sync && (slot_q != 3'd0)) begin
                    // Early sync: drop the partial frame, realign on this beat.
                    sync_err_nxt  = 1'b1;
                    shadow_nxt[0] = bus.in;
                    slot_nxt      = 3'd1;
                end else if (!bus.frame_sync && (slot_q == 3'd0) && SYNC_EVERY_FRAME) begin
                    // Missing sync: lock is lost and the beat is not kept.
                    sync_err_nxt = 1'b1;
                    slot_nxt     = 3'd0;
                    state_nxt    = HUNT;
                end else begin
                    shadow_nxt[slot_q] = bus.in;
                    slot_nxt           = slot_q + 3'd1;
                    complete           = (slot_q == 3'd7);
                end
            end
        end

        // A completing frame takes priority over consumption of the old one;
        // it is only an overrun when the old frame was not accepted.
        if (complete) begin
            out_nxt       = {bus.in, shadow_q[6:0]};
            out_valid_nxt = 1'b1;
            overrun_nxt   = out_valid_q && !bus.out_ready;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot      = slot_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.sync_err  = sync_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1x8
// Drives two demux instances (SYNC_EVERY_FRAME = 1 and 0) with the same
// stream and checks both against a frame-level reference model every cycle.
// A vector table covers the basic frame; hand sequences cover hunting,
// resync, missing sync, overrun and mid-frame reset; a random phase follows.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1x8;

    logic clk;
    logic rst_n;

    tdm_demux_1x8_if bus1 ();
    tdm_demux_1x8_if bus0 ();

    tdm_demux_1x8 #(.SYNC_EVERY_FRAME(1'b1)) u_sef1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    tdm_demux_1x8 #(.SYNC_EVERY_FRAME(1'b0)) u_sef0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model, index 0 = SYNC_EVERY_FRAME 1, index 1 = SYNC_EVERY_FRAME 0.
    // The frame in progress is a queue of received bits; its length is the slot.
    bit         m_locked [2];
    bit         m_q      [2][$];
    logic [7:0] m_out    [2];
    bit         m_ov     [2];
    bit         m_serr   [2];
    bit         m_orun   [2];

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_locked[p] = 1'b0;
            m_q[p].delete();
            m_out[p]  = 8'd0;
            m_ov[p]   = 1'b0;
            m_serr[p] = 1'b0;
            m_orun[p] = 1'b0;
        end
    endtask

    task automatic model_step(input bit i, input bit fs, input bit v, input bit r);
        for (int p = 0; p < 2; p++) begin
            bit       done;
            int       word;
            done = 1'b0;
            word = 0;
            m_serr[p] = 1'b0;
            m_orun[p] = 1'b0;
            if (v) begin
                if (!m_locked[p]) begin
                    if (fs) begin
                        m_q[p].delete();
                        m_q[p].push_back(i);
                        m_locked[p] = 1'b1;
                    end
                end else if (fs && m_q[p].size() != 0) begin
                    m_serr[p] = 1'b1;
                    m_q[p].delete();
                    m_q[p].push_back(i);
                end else if (!fs && m_q[p].size() == 0 && p == 0) begin
                    m_serr[p]   = 1'b1;
                    m_locked[p] = 1'b0;
                end else begin
                    m_q[p].push_back(i);
                    if (m_q[p].size() == 8) begin
                        for (int k = 0; k < 8; k++) word += int'(m_q[p][k]) * (1 << k);
                        done = 1'b1;
                        m_q[p].delete();
                    end
                end
            end
            if (done) begin
                m_orun[p] = m_ov[p] && !r;
                m_out[p]  = word[7:0];
                m_ov[p]   = 1'b1;
            end else if (m_ov[p] && r) begin
                m_ov[p] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int p, input logic [7:0] o, input logic ov, input logic [2:0] sl,
                       input logic lk, input logic se, input logic orn);
        string n;
        n = (p == 0) ? "sef1" : "sef0";
        chk({n, ".out"},       o,   m_out[p]);
        chk({n, ".out_valid"}, ov,  m_ov[p]);
        chk({n, ".slot"},      sl,  m_q[p].size());
        chk({n, ".locked"},    lk,  m_locked[p]);
        chk({n, ".sync_err"},  se,  m_serr[p]);
        chk({n, ".overrun"},   orn, m_orun[p]);
    endtask

    task automatic compare_all();
        cmp(0, bus1.out, bus1.out_valid, bus1.slot, bus1.locked, bus1.sync_err, bus1.overrun);
        cmp(1, bus0.out, bus0.out_valid, bus0.slot, bus0.locked, bus0.sync_err, bus0.overrun);
    endtask

    task automatic drive(input bit i, input bit fs, input bit v, input bit r);
        bus1.in = i; bus1.frame_sync = fs; bus1.in_valid = v; bus1.out_ready = r;
        bus0.in = i; bus0.frame_sync = fs; bus0.in_valid = v; bus0.out_ready = r;
    endtask

    task automatic cycle(input bit i, input bit fs, input bit v, input bit r);
        drive(i, fs, v, r);
        model_step(i, fs, v, r);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send_frame(input logic [7:0] w, input bit sync, input bit r);
        for (int k = 0; k < 8; k++) cycle(w[k], sync && (k == 0), 1'b1, r);
    endtask

    // Asserts reset away from the clock edge and checks the outputs clear
    // before any further edge arrives.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        bit       i;
        bit       fs;
        bit       v;
        bit       r;
        bit [7:0] eout;
        bit       eov;
        bit       elock;
        bit [2:0] eslot;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        int         phase;
        bit         v, fs;

        // in = 1,0,1,1,0,0,1,0 for slots 0..7 -> 8'h4D
        tbl[0] = '{1, 1, 1, 1, 8'h00, 0, 1, 3'd1};
        tbl[1] = '{0, 0, 1, 1, 8'h00, 0, 1, 3'd2};
        tbl[2] = '{1, 0, 1, 1, 8'h00, 0, 1, 3'd3};
        tbl[3] = '{1, 0, 1, 1, 8'h00, 0, 1, 3'd4};
        tbl[4] = '{0, 0, 1, 1, 8'h00, 0, 1, 3'd5};
        tbl[5] = '{0, 0, 1, 1, 8'h00, 0, 1, 3'd6};
        tbl[6] = '{1, 0, 1, 1, 8'h00, 0, 1, 3'd7};
        tbl[7] = '{0, 0, 1, 1, 8'h4D, 1, 1, 3'd0};
        tbl[8] = '{0, 0, 0, 1, 8'h4D, 0, 1, 3'd0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Basic frame from the vector table.
        for (int n = 0; n < 9; n++) begin
            cycle(tbl[n].i, tbl[n].fs, tbl[n].v, tbl[n].r);
            chk($sformatf("tbl%0d.out", n),       bus1.out,       tbl[n].eout);
            chk($sformatf("tbl%0d.out_valid", n), bus1.out_valid, tbl[n].eov);
            chk($sformatf("tbl%0d.locked", n),    bus1.locked,    tbl[n].elock);
            chk($sformatf("tbl%0d.slot", n),      bus1.slot,      tbl[n].eslot);
        end

        // Same frame with gaps between beats.
        w = 8'h4D;
        for (int k = 0; k < 8; k++) begin
            cycle(w[k], k == 0, 1'b1, 1'b1);
            if (k < 7) begin
                chk("gap.out_valid_early", bus1.out_valid, 1'b0);
                cycle(1'b0, 1'b0, 1'b0, 1'b1);
                chk("gap.slot_hold", bus1.slot, k + 1);
            end
        end
        chk("gap.out_valid", bus1.out_valid, 1'b1);
        chk("gap.out",       bus1.out,       8'h4D);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap.out_valid_clear", bus1.out_valid, 1'b0);

        // Hunting: unsynced beats are ignored silently.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
            chk("hunt.locked",   bus1.locked,   1'b0);
            chk("hunt.sync_err", bus1.sync_err, 1'b0);
        end
        send_frame(8'hA5, 1'b1, 1'b1);
        chk("hunt.out",       bus1.out,       8'hA5);
        chk("hunt.out_valid", bus1.out_valid, 1'b1);

        // Early sync at slot 3 realigns; the resync beat becomes bit 0.
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        chk("resync.slot_before", bus1.slot, 3'd3);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("resync.sync_err", bus1.sync_err, 1'b1);
        chk("resync.slot",     bus1.slot,     3'd1);
        chk("resync.locked",   bus1.locked,   1'b1);
        w = 8'hC3;
        for (int k = 1; k < 8; k++) begin
            cycle(w[k], 1'b0, 1'b1, 1'b1);
            chk("resync.no_err", bus1.sync_err, 1'b0);
        end
        chk("resync.out",       bus1.out,       8'hC3);
        chk("resync.out_valid", bus1.out_valid, 1'b1);

        // Second frame missing its sync.
        send_frame(8'h5A, 1'b1, 1'b1);
        w = 8'h96;
        cycle(w[0], 1'b0, 1'b1, 1'b1);
        chk("nosync.sef1_err",    bus1.sync_err, 1'b1);
        chk("nosync.sef1_locked", bus1.locked,   1'b0);
        chk("nosync.sef0_err",    bus0.sync_err, 1'b0);
        for (int k = 1; k < 8; k++) cycle(w[k], 1'b0, 1'b1, 1'b1);
        chk("nosync.sef1_out_valid", bus1.out_valid, 1'b0);
        chk("nosync.sef1_out",       bus1.out,       8'h5A);
        chk("nosync.sef0_out_valid", bus0.out_valid, 1'b1);
        chk("nosync.sef0_out",       bus0.out,       8'h96);

        // Overrun with the consumer stalled, then drain.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h11, 1'b1, 1'b0);
        chk("ovr.first_no_overrun", bus1.overrun, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("ovr.overrun",   bus1.overrun,   1'b1);
        chk("ovr.out",       bus1.out,       8'h22);
        chk("ovr.out_valid", bus1.out_valid, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr.pulse_once", bus1.overrun, 1'b0);
        chk("ovr.hold_out",   bus1.out,     8'h22);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr.drained", bus1.out_valid, 1'b0);

        // Reset in the middle of a frame.
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        do_reset();
        chk("rst.locked", bus1.locked, 1'b0);
        chk("rst.slot",   bus1.slot,   3'd0);

        // Random phase: mostly aligned syncs with occasional faults.
        phase = 0;
        for (int n = 0; n < 3000; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            fs = 1'b0;
            if (v) begin
                fs    = (phase == 0) ^ ($urandom_range(0, 19) == 0);
                phase = (phase + 1) % 8;
            end
            cycle(1'($urandom_range(0, 1)), fs, v, $urandom_range(0, 9) < 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Receiving end of the 8-way bit-select path: the mux serialises in[0..7] onto one line; this block rebuilds the 8-bit word.
- Takes a 1-bit time-division stream, one bit per valid beat, slot 0 marked by frame_sync.
- Routes each beat into its slot position and presents the completed 8-bit frame through a valid/ready output register.

Parameters:
- SYNC_EVERY_FRAME, 1: 1 = frame_sync is required on every slot-0 beat while locked; 0 = frame_sync is needed only to acquire lock.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  1  serial data bit for the current slot.
- in_valid  input  1  beat qualifier; in and frame_sync are sampled only when high.
- frame_sync  input  1  marks the current beat as slot 0.
- out  output  8  completed frame; out[k] holds the bit received in slot k.
- out_valid  output  1  out holds an unconsumed frame.
- out_ready  input  1  consumer accepts out when out_valid && out_ready.
- slot  output  3  slot index expected on the next beat.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing error.
- overrun  output  1  one-cycle pulse when an unconsumed frame is overwritten.

Behaviour:
- Reset (async assert, sync release): out=0, out_valid=0, slot=0, locked=0, sync_err=0, overrun=0, shadow register=0, state=HUNT.
- Beats are processed only when in_valid=1. With in_valid=0, state, slot and shadow hold.
- HUNT:
  - Beats without frame_sync are discarded; no error is raised.
  - A beat with frame_sync writes shadow[0]=in, sets slot=1 and moves to LOCKED.
- LOCKED, beat at slot k with no framing fault:
  - Writes shadow[k]=in.
  - Sets slot=(k+1) mod 8, wrapping 7 to 0.
- Frame completion (beat at slot 7):
  - On the next edge, out={in, shadow[6:0]} and out_valid=1.
  - Latency: 1 cycle from the slot-7 beat to out_valid.
- Framing fault, frame_sync on a beat at slot k≠0:
  - sync_err pulses.
  - The partial frame is discarded; the beat is taken as slot 0 (shadow[0]=in, slot=1).
  - Block stays LOCKED.
- Framing fault, slot-0 beat without frame_sync:
  - With SYNC_EVERY_FRAME=1: sync_err pulses, the beat is dropped, slot=0, state goes to HUNT.
  - With SYNC_EVERY_FRAME=0: the beat is accepted as normal.
- Output handshake:
  - out_valid clears on the edge where out_valid && out_ready, unless a frame completes on that same edge, in which case out_valid stays 1 with the new data and there is no overrun.
  - A frame completing while out_valid=1 and out_ready=0 overwrites out, keeps out_valid=1 and pulses overrun.
  - out is stable while out_valid=1 and no new frame completes.
- Shadow bits for slots not yet written in the current frame are don't-care internally. Every slot is rewritten before completion, so out never exposes a stale bit from a previous frame.
- Reset mid-frame: everything returns to reset values immediately (async); the partial frame is lost and the block returns to HUNT.
- sync_err and overrun are registered, high for exactly one cycle per event. Both may pulse in the same cycle.

Test Plan:
- Reset, then 8 back-to-back beats with in = 1,0,1,1,0,0,1,0 (slot 0 to 7) and frame_sync on the first, out_ready=1 -> one cycle after the last beat, out=8'h4D and out_valid=1 for 1 cycle; locked=1.
- Same frame with in_valid toggling 1/0 every cycle -> out=8'h4D; out_valid rises exactly 1 cycle after the 8th valid beat; slot holds during gaps.
- In HUNT, 5 beats without sync, then a synced frame for 8'hA5 -> the first 5 beats are ignored, out=8'hA5, no sync_err.
- Locked, frame_sync asserted on slot 3 -> sync_err for 1 cycle, slot becomes 1, and the next 7 beats complete a frame whose bit 0 is the resync beat's data.
- SYNC_EVERY_FRAME=1, two frames with the second slot-0 beat lacking sync -> sync_err pulses, locked=0, no second out_valid. Repeat with SYNC_EVERY_FRAME=0 -> the second frame is delivered with no error.
- out_ready=0 across frames 8'h11 then 8'h22 -> overrun pulses once, out=8'h22, out_valid stays 1. Then out_ready=1 -> out_valid clears next edge. Assert rst_n mid-frame -> all outputs 0 immediately.
